// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host states, frame size and default timing constants.
package ps2_pkg;
  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQUEST, S_SEND, S_ACK, S_RELEASE} ps2_state_e;
  localparam int FRAME_BITS             = 11;
  localparam int INHIBIT_CYCLES_DEF     = 2800;
  localparam int FIRST_EDGE_TIMEOUT_DEF = 420000;
  localparam int FRAME_TIMEOUT_DEF      = 56000;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_sync.sv
// ps2_sync: 2-flop synchronisers for the PS/2 pads and a falling-edge detector on the clock line.
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic clk_fall_o
);
  logic [1:0] clk_q, data_q;
  logic clk_prev_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      clk_q      <= 2'b11;
      data_q     <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_q      <= {clk_q[0], ps2_clk_i};
      data_q     <= {data_q[0], ps2_data_i};
      clk_prev_q <= clk_q[1];
    end
  assign clk_s_o    = clk_q[1];
  assign data_s_o   = data_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one byte host-to-device over PS/2 open-drain lines.
// Define PS2_TX_RETRY_EN to retry a failed frame up to 2 times before reporting error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES     = INHIBIT_CYCLES_DEF,
  parameter int FIRST_EDGE_TIMEOUT = FIRST_EDGE_TIMEOUT_DEF,
  parameter int FRAME_TIMEOUT      = FRAME_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int CW = cnt_width(INHIBIT_CYCLES, FIRST_EDGE_TIMEOUT, FRAME_TIMEOUT);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] FET_LAST = CW'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [CW-1:0] FRM_LAST = CW'(FRAME_TIMEOUT - 1);
  localparam logic [3:0]    STOP_EDGE = 4'(FRAME_BITS - 2);

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    nb_q, nb_d;
  logic [9:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d, ld_byte;
  logic          tx_ready_q, busy_q, done_q, error_q, clk_oe_q, data_oe_q;
  logic          done_d, error_d, clk_oe_d, data_oe_d, bit_oe, start, restart, fail;
  logic          clk_s, data_s, clk_fall;

  ps2_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .clk_s_o   (clk_s),
    .data_s_o  (data_s),
    .clk_fall_o(clk_fall)
  );

`ifdef PS2_TX_RETRY_EN
  logic [1:0] rt_q, rt_d;
  always_ff @(posedge clk) rt_q <= !rst_n ? 2'd0 : rt_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    nb_d    = nb_q;
    sh_d    = sh_q;
    data_d  = data_q;
    bit_oe  = data_oe_q;
    start   = 1'b0;
    restart = 1'b0;
    fail    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        start = tx_valid & tx_ready_q;
      end
      S_INHIBIT:
        if (cnt_q == INH_LAST) begin
          state_d = S_REQUEST;
          cnt_d   = '0;
        end
      S_REQUEST:
        if (clk_fall) begin
          state_d = S_SEND;
          cnt_d   = '0;
          nb_d    = 4'd1;
          bit_oe  = ~sh_q[0];
          sh_d    = {1'b1, sh_q[9:1]};
        end else if (cnt_q == FET_LAST) fail = 1'b1;
      S_SEND:
        if (cnt_q == FRM_LAST) fail = 1'b1;
        else if (clk_fall) begin
          nb_d    = nb_q + 4'd1;
          bit_oe  = ~sh_q[0];
          sh_d    = {1'b1, sh_q[9:1]};
          state_d = nb_q == STOP_EDGE ? S_ACK : S_SEND;
        end
      S_ACK:
        if (cnt_q == FRM_LAST) fail = 1'b1;
        else if (clk_fall) begin
          fail    = data_s;
          state_d = S_RELEASE;
        end
      S_RELEASE:
        if (clk_s & data_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      default: state_d = S_IDLE;
    endcase
`ifdef PS2_TX_RETRY_EN
    rt_d = state_q == S_IDLE ? 2'd0 : rt_q;
    if (fail && rt_q != 2'd2) begin
      fail    = 1'b0;
      restart = 1'b1;
      rt_d    = rt_q + 2'd1;
    end
`endif
    ld_byte = start ? tx_data : data_q;
    if (start) data_d = tx_data;
    if (start | restart) begin
      state_d = S_INHIBIT;
      cnt_d   = '0;
      nb_d    = '0;
      sh_d    = {1'b1, odd_parity(ld_byte), ld_byte};
    end
    if (fail) state_d = S_IDLE;
    error_d   = fail;
    clk_oe_d  = state_d == S_INHIBIT;
    // start bit goes low only in the last inhibit cycle, then is held through REQUEST
    data_oe_d = state_d == S_INHIBIT ? cnt_d == INH_LAST :
                state_d == S_REQUEST ? 1'b1 :
                state_d == S_SEND    ? bit_oe : 1'b0;
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      nb_q       <= '0;
      sh_q       <= '0;
      data_q     <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nb_q       <= nb_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      tx_ready_q <= state_d == S_IDLE;
      busy_q     <= state_d != S_IDLE;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
    end

  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: random and directed frames against a keyboard model on open-drain PS/2 lines.
module tb_ps2_host_tx;
  localparam int INH = 40, FET = 3000, FTO = 4000, H = 12;
`ifdef PS2_TX_RETRY_EN
  localparam int PHASES = 3;
`else
  localparam int PHASES = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0, tx_valid = 1'b0, dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe, busy, done, error;
  int n_chk = 0, n_err = 0;
  int cyc = 0, inh_n = 0, run = 0, inh_len = 0, rel_cyc = 0, both_n = 0;
  int done_n = 0, err_n = 0, err_cyc = 0, clash_n = 0;
  logic prev_coe = 1'b0;
  logic [1:0] err_oe = 2'b00;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_coe <= ps2_clk_oe;
    if (ps2_clk_oe & ~prev_coe) inh_n <= inh_n + 1;
    if (ps2_clk_oe) run <= prev_coe ? run + 1 : 1;
    if (~ps2_clk_oe & prev_coe) begin
      inh_len <= run;
      rel_cyc <= cyc;
    end
    if (ps2_clk_oe & ps2_data_oe) both_n <= both_n + 1;
    if (done) done_n <= done_n + 1;
    if (error) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
      err_oe  <= {ps2_clk_oe, ps2_data_oe};
    end
    if (done & error) clash_n <= clash_n + 1;
  end

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .FIRST_EDGE_TIMEOUT(FET), .FRAME_TIMEOUT(FTO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2) == 0;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("accept", 32'({busy, tx_ready}), 32'd2);
  endtask

  task automatic dev_frame(input bit ack, input int n_edges, output logic [10:0] got);
    int t = 0;
    got = '0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("rts", 32'(ps2_data_oe & ~ps2_clk_oe), 32'd1);
    repeat (H) @(negedge clk);
    got[0] = ps2_data_i;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (4) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      if (k <= 10) got[k] = ps2_data_i;
      if (k < n_edges || n_edges == 11) begin
        dev_clk_low = 1'b0;
        repeat (H) @(negedge clk);
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (!tx_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check(tag, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [10:0] got;
    logic [7:0] d;
    int d0, e0, p0, b0, t;
    repeat (3) @(negedge clk);
    check("reset", 32'({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, error}), 32'h20);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      d = i == 0 ? 8'hED : i == 1 ? 8'h00 : i == 2 ? 8'h01 : 8'($urandom);
      d0 = done_n; e0 = err_n; p0 = inh_n; b0 = both_n;
      send(d);
      dev_frame(1'b1, 11, got);
      wait_idle("idle");
      check("frame", 32'(got), 32'(frame_of(d)));
      check("done", done_n - d0, 1);
      check("no_err", err_n - e0, 0);
      check("inh_len", inh_len, INH);
      check("phases", inh_n - p0, 1);
      check("both_oe", both_n - b0, 1);
    end
    d = 8'($urandom);
    d0 = done_n; p0 = inh_n;
    send(d);
    tx_data  = ~d;
    tx_valid = 1'b1;
    fork
      dev_frame(1'b1, 11, got);
      begin
        repeat (INH + 10 * H) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_idle("ign_idle");
    repeat (20) @(negedge clk);
    check("ign_frame", 32'(got), 32'(frame_of(d)));
    check("ign_done", done_n - d0, 1);
    check("ign_phases", inh_n - p0, 1);
    check("ign_busy", 32'(busy), 0);
    d0 = done_n; e0 = err_n; p0 = inh_n;
    send(8'h5A);
    t = 0;
    while (err_n == e0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check("fet_err", err_n - e0, 1);
    check("fet_done", done_n - d0, 0);
    check("fet_time", err_cyc - rel_cyc, FET);
    check("fet_oe", 32'(err_oe), 0);
    check("fet_phases", inh_n - p0, PHASES);
    d0 = done_n; e0 = err_n; p0 = inh_n;
    send(8'hA5);
    for (int p = 0; p < PHASES; p++) dev_frame(1'b0, 11, got);
    wait_idle("nack_idle");
    check("nack_frame", 32'(got), 32'(frame_of(8'hA5)));
    check("nack_err", err_n - e0, 1);
    check("nack_done", done_n - d0, 0);
    check("nack_phases", inh_n - p0, PHASES);
    d0 = done_n; e0 = err_n;
    send(8'h3C);
    dev_frame(1'b1, 5, got);
    dev_clk_low = 1'b0;
    wait_idle("fto_idle");
    check("fto_err", err_n - e0, 1);
    check("fto_done", done_n - d0, 0);
    send(8'h96);
    dev_frame(1'b1, 4, got);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_abort", 32'({ps2_clk_oe, ps2_data_oe, tx_ready, busy}), 32'h2);
    rst_n = 1'b1;
    dev_clk_low = 1'b0;
    repeat (10) @(negedge clk);
    d = 8'($urandom);
    d0 = done_n; e0 = err_n;
    send(d);
    dev_frame(1'b1, 11, got);
    wait_idle("rst_idle");
    check("rst_frame", 32'(got), 32'(frame_of(d)));
    check("rst_done", done_n - d0, 1);
    check("rst_no_err", err_n - e0, 0);
    check("clash", clash_n, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2800: clock-low hold time (100 us at 28 MHz).
REQ-002 SHALL have parameter FIRST_EDGE_TIMEOUT, default 420000: limit from releasing the clock to the first device falling edge (15 ms).
REQ-003 SHALL have parameter FRAME_TIMEOUT, default 56000: limit from the first falling edge to the ACK (2 ms).
REQ-004 clk  in  1  system clock (cpuClock domain).
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 tx_data  in  8  command byte to keyboard (e.g. 0xED, LED mask).
REQ-007 tx_valid  in  1  request; byte accepted when tx_valid & tx_ready.
REQ-008 tx_ready  out  1  high only in IDLE.
REQ-009 ps2_clk_i  in  1  raw PS/2 clock pad input.
REQ-010 ps2_data_i  in  1  raw PS/2 data pad input.
REQ-011 ps2_clk_oe  out  1  1 = drive clock low; 0 = release.
REQ-012 ps2_data_oe  out  1  1 = drive data low; 0 = release.
REQ-013 busy  out  1  high outside IDLE; the receiver uses it to ignore the line.
REQ-014 done  out  1  one-cycle pulse when the device ACKs.
REQ-015 error  out  1  one-cycle pulse on a timeout or missing ACK.

Function
REQ-016 SHALL synchronise both pad inputs through 2 flops and detect falling edges of the synchronised clock.
REQ-017 States SHALL be IDLE, INHIBIT, REQUEST, SEND, ACK and RELEASE.
REQ-018 On accept, SHALL latch tx_data and odd parity (~^tx_data), enter INHIBIT, and assert busy the following cycle.
REQ-019 INHIBIT SHALL hold ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe SHALL rise in the final INHIBIT cycle (start bit).
REQ-020 REQUEST SHALL hold ps2_clk_oe=0 and ps2_data_oe=1; the first falling edge moves to SEND; exceeding FIRST_EDGE_TIMEOUT SHALL give error.
REQ-021 SEND SHALL present one bit per device falling edge, with ps2_data_oe = ~bit: falling edges 1-8 carry data LSB first, edge 9 parity, edge 10 stop (ps2_data_oe=0).
REQ-022 At the 11th falling edge, ps2_data_i low (synchronised) SHALL go to RELEASE; high SHALL give error.
REQ-023 FRAME_TIMEOUT SHALL be counted from the first falling edge; expiry in SEND or ACK SHALL give error.
REQ-024 RELEASE SHALL wait for both synchronised lines high, then pulse done and return to IDLE.
REQ-025 On error, both oe outputs SHALL be 0 in the same cycle error pulses, and the next state SHALL be IDLE.
REQ-026 done and error SHALL never assert together.
REQ-027 tx_valid outside IDLE SHALL be ignored; no queueing.
REQ-028 All outputs SHALL be registered; ps2_clk_oe and ps2_data_oe SHALL never both be 1 except during the last INHIBIT cycle.

Reset
REQ-029 When rst_n is sampled low: state IDLE, tx_ready=1, busy=0, done=0, error=0, both oe=0, and counters and shift register cleared; this SHALL abort any frame in progress.

Configuration
REQ-030 With PS2_TX_RETRY_EN defined, an error condition SHALL restart from INHIBIT with the latched byte, up to 2 retries; error SHALL pulse only when the final retry fails, and busy SHALL stay high throughout.
REQ-031 Without PS2_TX_RETRY_EN, error SHALL pulse on the first failure, with no retry logic synthesised.

Structure
REQ-032 Package ps2_pkg SHALL hold the state enumeration, the frame bit count (11) and the default timing constants.
REQ-033 Sub-module ps2_sync SHALL contain the 2-flop synchronisers and the falling-edge detector, shared with the receiver.

Verification
REQ-034 tx_data=0xED, keyboard model ACKs -> clock low 2800 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop 1, done pulse, tx_ready back to 1.
REQ-035 tx_data=0x00 -> parity bit 1; tx_data=0x01 -> parity bit 0; both end in done.
REQ-036 Model never clocks -> error exactly 420000 cycles after clock release, with both oe already 0.
REQ-037 Model holds data high at the 11th edge -> error, no done; with PS2_TX_RETRY_EN, 3 INHIBIT phases then a single error.
REQ-038 rst_n low during bit 4 -> next cycle both oe=0 and tx_ready=1; a new request then completes normally.
REQ-039 tx_valid held high during SEND with a different byte -> ignored; the wire carries only the original byte.
